// File: rtl/dense_layer_engine.sv
// Fully-connected layer: streams in an N_IN vector, then emits N_OUT saturated fixed-point dot products plus bias.
// Optional ReLU activation when DENSE_LAYER_RELU_EN is defined.
module dense_layer_engine #(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8,
  parameter int N_IN   = 64,
  parameter int N_OUT  = 10,
  parameter int ACC_W  = 40,
  localparam int WA_W  = (N_IN * N_OUT > 1) ? $clog2(N_IN * N_OUT) : 1,
  localparam int BA_W  = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              s_tvalid,
  output logic              s_tready,
  input  logic [DATA_W-1:0] s_tdata,
  output logic [WA_W-1:0]   w_addr,
  input  logic [DATA_W-1:0] w_rdata,
  output logic [BA_W-1:0]   b_addr,
  input  logic [DATA_W-1:0] b_rdata,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic [DATA_W-1:0] m_tdata,
  output logic              done
);
  localparam int IW = $clog2(N_IN);
  localparam int CW = $clog2(N_IN + 1);
  localparam logic [IW-1:0]   CNT_LAST = IW'(N_IN - 1);
  localparam logic [CW-1:0]   C_LAST   = CW'(N_IN);
  localparam logic [BA_W-1:0] J_LAST   = BA_W'(N_OUT - 1);
  localparam logic signed [ACC_W-1:0] SMAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SMIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, LOAD, MAC, BIAS, OUT} state_t;
  state_t state, state_nx;

  logic [IW-1:0]             cnt;
  logic [CW-1:0]             c;
  logic [BA_W-1:0]           j;
  logic signed [ACC_W-1:0]   acc;
  logic signed [DATA_W-1:0]  x [N_IN];
  logic signed [DATA_W-1:0]  w_hold, w_op, x_cur, sat, act;
  logic                      stall_q;
  logic [IW-1:0]             xi;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]   prod_ext, bias_ext, sum_b, shifted;
  logic                      beat;

  assign s_tready = en && !rst && !done && (state == IDLE || state == LOAD);
  assign m_tvalid = (state == OUT);
  assign beat     = s_tvalid && s_tready;
  assign b_addr   = j;
  // Address is held at the last weight while the final product drains.
  assign w_addr   = WA_W'(int'(j) * N_IN + ((c == C_LAST) ? (N_IN - 1) : int'(c)));

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, LOAD: if (beat) state_nx = (cnt == CNT_LAST) ? MAC : LOAD;
      MAC:        if (en && c == C_LAST) state_nx = BIAS;
      BIAS:       if (en) state_nx = OUT;
      OUT:        if (m_tready) state_nx = (j == J_LAST) ? IDLE : MAC;
      default:    state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // The ROM keeps sampling the frozen address during a stall, so the word
  // returned for the previous address is captured on the first stalled cycle.
  assign w_op     = stall_q ? w_hold : w_rdata;
  assign xi       = IW'(c - CW'(1));
  assign x_cur    = x[xi];
  assign prod     = x_cur * w_op;
  assign prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
  assign bias_ext = {{(ACC_W-DATA_W-FRAC_W){b_rdata[DATA_W-1]}}, b_rdata, {FRAC_W{1'b0}}};
  assign sum_b    = acc + bias_ext;
  assign shifted  = sum_b >>> FRAC_W;

  always_comb begin
    sat = shifted[DATA_W-1:0];
    if (shifted > SMAX)      sat = {1'b0, {(DATA_W-1){1'b1}}};
    else if (shifted < SMIN) sat = {1'b1, {(DATA_W-1){1'b0}}};
  end

`ifdef DENSE_LAYER_RELU_EN
  assign act = sat[DATA_W-1] ? '0 : sat;
`else
  assign act = sat;
`endif

  always_ff @(posedge clk) begin
    if (beat) x[cnt] <= s_tdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      c       <= '0;
      j       <= '0;
      acc     <= '0;
      m_tdata <= '0;
      done    <= 1'b0;
      stall_q <= 1'b0;
      w_hold  <= '0;
    end else begin
      done    <= 1'b0;
      stall_q <= 1'b0;
      case (state)
        IDLE, LOAD: begin
          if (en && state == IDLE) begin
            acc <= '0;
            j   <= '0;
          end
          if (beat) cnt <= (cnt == CNT_LAST) ? '0 : cnt + IW'(1);
        end
        MAC: begin
          stall_q <= !en;
          if (!en && !stall_q) w_hold <= w_rdata;
          if (en) begin
            c <= (c == C_LAST) ? '0 : c + CW'(1);
            if (c != '0) acc <= acc + prod_ext;
          end
        end
        BIAS: begin
          if (en) begin
            acc     <= sum_b;
            m_tdata <= act;
          end
        end
        OUT: begin
          if (m_tready) begin
            acc <= '0;
            c   <= '0;
            if (j == J_LAST) begin
              done <= 1'b1;
              j    <= '0;
            end else begin
              j <= j + BA_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_dense_layer_engine.sv
// Self-checking bench for dense_layer_engine (N_IN=4, N_OUT=2) with ROM models and an arithmetic reference.
module tb_dense_layer_engine;
  localparam int NI = 4;
  localparam int NO = 2;

  logic        clk = 1'b0;
  logic        rst, en, s_tvalid, s_tready, m_tvalid, m_tready, done;
  logic [15:0] s_tdata, w_rdata, b_rdata, m_tdata;
  logic [2:0]  w_addr;
  logic [0:0]  b_addr;

  int checks = 0;
  int errors = 0;

  logic [15:0] xv   [NI];
  logic [15:0] wmem [NI*NO];
  logic [15:0] bmem [NO];

  dense_layer_engine #(.DATA_W(16), .FRAC_W(8), .N_IN(NI), .N_OUT(NO), .ACC_W(40)) dut (
    .clk(clk), .rst(rst), .en(en),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
    .w_addr(w_addr), .w_rdata(w_rdata),
    .b_addr(b_addr), .b_rdata(b_rdata),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
    .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    w_rdata <= wmem[w_addr];
    b_rdata <= bmem[b_addr];
  end

  // Reference: exact dot product, floor-divide by 2^8, clamp, optional ReLU.
  function automatic logic [15:0] model(input int jj);
    longint s = 0;
    for (int i = 0; i < NI; i++)
      s += longint'($signed(xv[i])) * longint'($signed(wmem[jj*NI+i]));
    s += longint'($signed(bmem[jj])) * 256;
    s = s >>> 8;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
`ifdef DENSE_LAYER_RELU_EN
    if (s < 0) s = 0;
`endif
    return 16'(s);
  endfunction

  task automatic send_vec(input int stall_at);
    int t, cyc;
    cyc = 0;
    for (int i = 0; i < NI; i++) begin
      s_tvalid = 1'b1;
      s_tdata  = xv[i];
      if (i == stall_at) begin en = 1'b0; #1; end
      t = 0;
      while (!s_tready && t < 100) begin
        @(negedge clk); t++; cyc++;
        if (t == 3 && i == stall_at) begin en = 1'b1; #1; end
      end
      if (!s_tready) begin
        checks++; errors++;
        $display("FAIL send_timeout beat %0d: s_tready never rose", i);
      end
      @(negedge clk); cyc++;
    end
    s_tvalid = 1'b0;
    checks++;
    if (cyc !== NI + ((stall_at >= 0) ? 3 : 0)) begin
      errors++;
      $display("FAIL load_cycles: got %0d want %0d", cyc, NI + ((stall_at >= 0) ? 3 : 0));
    end
  endtask

  task automatic recv(input logic [15:0] exp [NO], input int hold, input bit mac_stall);
    int lat, want;
    m_tready = (hold == 0);
    for (int k = 0; k < NO; k++) begin
      lat = 0;
      while (!m_tvalid && lat < 60) begin
        if (mac_stall && k == 0) begin
          if (lat == 2) en = 1'b0;
          if (lat == 5) en = 1'b1;
        end
        @(negedge clk); lat++;
      end
      want = NI + 2 + ((mac_stall && k == 0) ? 3 : 0);
      checks++;
      if (lat !== want) begin
        errors++; $display("FAIL latency neuron %0d: got %0d want %0d", k, lat, want);
      end
      checks++;
      if (m_tdata !== exp[k]) begin
        errors++; $display("FAIL result neuron %0d: got %h want %h", k, m_tdata, exp[k]);
      end
      if (hold > 0) begin
        for (int h = 0; h < hold; h++) begin
          @(negedge clk);
          checks++;
          if (m_tvalid !== 1'b1 || m_tdata !== exp[k] || b_addr !== 1'(k)) begin
            errors++;
            $display("FAIL hold neuron %0d cyc %0d: valid=%b data=%h j=%0d want 1 %h %0d",
                     k, h, m_tvalid, m_tdata, b_addr, exp[k], k);
          end
        end
        m_tready = 1'b1;
        @(negedge clk);
        m_tready = 1'b0;
      end else begin
        @(negedge clk);
      end
      if (k < NO - 1) begin
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL done_early neuron %0d: got %b want 0", k, done); end
      end
    end
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL done_pulse: got %b want 1", done); end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL done_width: got %b want 0", done); end
    m_tready = 1'b1;
  endtask

  task automatic run_vec(input logic [15:0] exp [NO], input int hold, input int load_stall, input bit mac_stall);
    send_vec(load_stall);
    recv(exp, hold, mac_stall);
  endtask

  task automatic fill(input int xval, input int wval, input int bval);
    for (int i = 0; i < NI; i++) xv[i] = 16'(xval);
    for (int i = 0; i < NI*NO; i++) wmem[i] = 16'(wval);
    for (int i = 0; i < NO; i++) bmem[i] = 16'(bval);
  endtask

  task automatic fill_random(input bit full);
    for (int i = 0; i < NI; i++) xv[i] = full ? 16'($urandom) : 16'($urandom_range(0, 2047)) - 16'd1024;
    for (int i = 0; i < NI*NO; i++) wmem[i] = full ? 16'($urandom) : 16'($urandom_range(0, 511)) - 16'd256;
    for (int i = 0; i < NO; i++) bmem[i] = full ? 16'($urandom) : 16'($urandom_range(0, 2047)) - 16'd1024;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; s_tvalid = 1'b0; s_tdata = '0; m_tready = 1'b1;
    fill(0, 0, 0);
    repeat (3) @(negedge clk);
    checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL rst_s_tready: got %b want 0", s_tready); end
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL rst_m_tvalid: got %b want 0", m_tvalid); end
    checks++; if (m_tdata !== 16'h0) begin errors++; $display("FAIL rst_m_tdata: got %h want 0", m_tdata); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", done); end
    checks++; if (w_addr !== 3'd0) begin errors++; $display("FAIL rst_w_addr: got %0d want 0", w_addr); end
    checks++; if (b_addr !== 1'd0) begin errors++; $display("FAIL rst_b_addr: got %0d want 0", b_addr); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [15:0] e [NO];
    fill(16'h0100, 16'h0080, 16'h0100);
    e[0] = 16'h0300; e[1] = 16'h0300;
    run_vec(e, 0, -1, 1'b0);
    fill(16'h7FFF, 16'h7FFF, 16'h7FFF);
    e[0] = 16'h7FFF; e[1] = 16'h7FFF;
    run_vec(e, 0, -1, 1'b0);
    fill(16'h7FFF, 16'h8000, 16'h7FFF);
`ifdef DENSE_LAYER_RELU_EN
    e[0] = 16'h0000; e[1] = 16'h0000;
`else
    e[0] = 16'h8000; e[1] = 16'h8000;
`endif
    run_vec(e, 0, -1, 1'b0);
    fill(16'h0100, 16'hFFC0, 16'h0000);
`ifdef DENSE_LAYER_RELU_EN
    e[0] = 16'h0000; e[1] = 16'h0000;
`else
    e[0] = 16'hFF00; e[1] = 16'hFF00;
`endif
    run_vec(e, 0, -1, 1'b0);
  endtask

  task automatic test_random();
    logic [15:0] e [NO];
    for (int n = 0; n < 8; n++) begin
      fill_random(n[0]);
      for (int k = 0; k < NO; k++) e[k] = model(k);
      run_vec(e, 0, -1, 1'b0);
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] e [NO];
    fill_random(1'b0);
    for (int k = 0; k < NO; k++) e[k] = model(k);
    run_vec(e, 5, -1, 1'b0);
  endtask

  task automatic test_en_stall();
    logic [15:0] e [NO];
    for (int n = 0; n < 2; n++) begin
      fill_random(1'b0);
      for (int k = 0; k < NO; k++) e[k] = model(k);
      run_vec(e, 0, 2, 1'b1);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] e [NO];
    int lat;
    fill(16'h0100, 16'h0080, 16'h0100);
    send_vec(-1);
    lat = 0;
    while (!m_tvalid && lat < 60) begin @(negedge clk); lat++; end
    checks++;
    if (m_tdata !== 16'h0300) begin errors++; $display("FAIL pre_reset_result: got %h want 0300", m_tdata); end
    @(negedge clk);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (s_tready !== 1'b0 || m_tvalid !== 1'b0 || m_tdata !== 16'h0 || done !== 1'b0 ||
        w_addr !== 3'd0 || b_addr !== 1'd0) begin
      errors++;
      $display("FAIL mid_reset: rdy=%b vld=%b data=%h done=%b wa=%0d ba=%0d want all 0",
               s_tready, m_tvalid, m_tdata, done, w_addr, b_addr);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    fill_random(1'b0);
    for (int k = 0; k < NO; k++) e[k] = model(k);
    run_vec(e, 0, -1, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [15:0] e [NO];
    for (int n = 0; n < 3; n++) begin
      fill_random(n[0]);
      for (int k = 0; k < NO; k++) e[k] = model(k);
      run_vec(e, 0, -1, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_en_stall();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
